bcd_scan_ctrl: RTL and testbench

Time-multiplexed display controller that shares one `bcd_4bits` converter instance between two 4-bit binary channels and drives a 4-digit common-anode 7-segment display. Scans four digit slots (A units, A tens, B units, B tens) at a prescaled rate, blanks at the start of every slot to prevent ghosting, and snapshots both channels once per frame so that each frame shows a consistent value. Sits between the board-level value sources (switches or counters) and the display pins.

---
 rtl/bcd_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: time-multiplexed 4-digit common-anode 7-segment controller.
//
// Two 4-bit binary channels (A, B) share one bcd_4bits converter. Four digit
// slots are scanned in order: A units, A tens, B units, B tens. Each slot lasts
// 2^DIV_W cycles. The first BLANK_CYC cycles of every slot are dark to avoid
// ghosting. Both channels are snapshotted once per frame, at the final tick of
// slot 3, so that a frame always shows one consistent pair of values.
//
// Parameters:
//   DIV_W      prescaler width, slot length = 2^DIV_W cycles
//   BLANK_CYC  dark cycles at the start of each slot (0 .. 2^DIV_W-1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          scan enable; while low the scan state holds and outputs go dark
//   num_a       channel A value 0..15, bit 0 is the MSB
//   num_b       channel B value 0..15, bit 0 is the MSB
//   seg         segments a..g, active-low, registered
//   an          digit enables, active-low, registered; an[k] selects slot k
//   frame_done  one-cycle pulse on the edge that takes a new snapshot
//
// Build option:
//   LZ_BLANK_EN  when defined, a tens digit whose snapshotted value is < 10
//                stays dark for its whole slot (leading-zero blanking).

// Binary 0..15 to two 7-segment digits (active-low, a..g in bits 0..6).
// y_a is the units digit, y_b the tens digit ("0" or "1").
module bcd_4bits (
    input  logic [0:3] num,
    output logic [0:6] y_a,
    output logic [0:6] y_b
);

    logic       ge_ten;
    logic [3:0] units;

    function automatic logic [0:6] digit_seg(input logic [3:0] d);
        logic [0:6] s;
        s = 7'b1111111;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        ge_ten = (num >= 4'd10);
        units  = ge_ten ? (num - 4'd10) : num;
        y_a    = digit_seg(units);
        y_b    = digit_seg(ge_ten ? 4'd1 : 4'd0);
    end

endmodule

module bcd_scan_ctrl #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [0:3] num_a,
    input  logic [0:3] num_b,
    output logic [0:6] seg,
    output logic [0:3] an,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        SlotAUnits = 2'd0,
        SlotATens  = 2'd1,
        SlotBUnits = 2'd2,
        SlotBTens  = 2'd3
    } slot_e;

    localparam logic [DIV_W-1:0] BlankThr = DIV_W'(BLANK_CYC);

    slot_e            slot_q, slot_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [0:3]       shadow_a_q, shadow_a_d;
    logic [0:3]       shadow_b_q, shadow_b_d;
    logic [0:3]       an_q, an_d;
    logic [0:6]       seg_q, seg_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             tens_slot;
    logic             lit;
    logic [0:3]       conv_in;
    logic [0:6]       y_a, y_b;

    bcd_4bits u_conv (
        .num (conv_in),
        .y_a (y_a),
        .y_b (y_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= SlotAUnits;
            cnt_q        <= '0;
            shadow_a_q   <= '0;
            shadow_b_q   <= '0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            cnt_q        <= cnt_d;
            shadow_a_q   <= shadow_a_d;
            shadow_b_q   <= shadow_b_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        shadow_a_d   = shadow_a_q;
        shadow_b_d   = shadow_b_q;
        frame_done_d = 1'b0;
        an_d         = 4'b1111;
        seg_d        = 7'b1111111;

        // A would-be tick with en low is suppressed, so the scan holds cleanly.
        tick = en && (cnt_q == '1);

        if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        if (tick) begin
            unique case (slot_q)
                SlotAUnits: slot_d = SlotATens;
                SlotATens:  slot_d = SlotBUnits;
                SlotBUnits: slot_d = SlotBTens;
                SlotBTens: begin
                    slot_d       = SlotAUnits;
                    shadow_a_d   = num_a;
                    shadow_b_d   = num_b;
                    frame_done_d = 1'b1;
                end
                default:    slot_d = SlotAUnits;
            endcase
        end

        // Slots 0-1 show channel A, slots 2-3 channel B; odd slots are tens.
        conv_in   = slot_q[1] ? shadow_b_q : shadow_a_q;
        tens_slot = slot_q[0];
        lit       = en && (cnt_q >= BlankThr);
`ifdef LZ_BLANK_EN
        if (tens_slot && (conv_in < 4'd10)) begin
            lit = 1'b0;
        end
`endif

        if (lit) begin
            unique case (slot_q)
                SlotAUnits: an_d = 4'b0111;
                SlotATens:  an_d = 4'b1011;
                SlotBUnits: an_d = 4'b1101;
                SlotBTens:  an_d = 4'b1110;
                default:    an_d = 4'b1111;
            endcase
            seg_d = tens_slot ? y_b : y_a;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl with DIV_W=3 (8-cycle slots) and
// BLANK_CYC=2. Covers reset state, six consecutive frames from a vector table
// (inputs changed mid-frame take effect only on the next frame), mid-slot
// reset, enable hold and a suppressed tick. Honours LZ_BLANK_EN if defined.
module tb_bcd_scan_ctrl;

`ifdef LZ_BLANK_EN
    localparam bit Lz = 1'b1;
`else
    localparam bit Lz = 1'b0;
`endif

    localparam logic [0:3] Dark4 = 4'b1111;
    localparam logic [0:6] Dark7 = 7'b1111111;

    logic       clk;
    logic       rst;
    logic       en;
    logic [0:3] num_a;
    logic [0:3] num_b;
    logic [0:6] seg;
    logic [0:3] an;
    logic       frame_done;

    int total;
    int bad;

    bcd_scan_ctrl #(
        .DIV_W     (3),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .num_a      (num_a),
        .num_b      (num_b),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per (frame, slot): inputs that the frame displays, and the
    // lit-cycle outputs. lz marks a tens digit that leading-zero blanking hides.
    typedef struct packed {
        logic [3:0] na;
        logic [3:0] nb;
        logic [0:3] an;
        logic [0:6] seg;
        logic       lz;
    } rec_t;

    rec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:3] exp_an;
        logic [0:6] exp_seg;
        rec_t       r;

        total = 0;
        bad   = 0;

        //            na     nb     an       seg          lz
        tbl[0]  = '{4'd0,  4'd0,  4'b0111, 7'b0000001, 1'b0};
        tbl[1]  = '{4'd0,  4'd0,  4'b1011, 7'b0000001, 1'b1};
        tbl[2]  = '{4'd0,  4'd0,  4'b1101, 7'b0000001, 1'b0};
        tbl[3]  = '{4'd0,  4'd0,  4'b1110, 7'b0000001, 1'b1};
        tbl[4]  = '{4'd13, 4'd7,  4'b0111, 7'b0000110, 1'b0};
        tbl[5]  = '{4'd13, 4'd7,  4'b1011, 7'b1001111, 1'b0};
        tbl[6]  = '{4'd13, 4'd7,  4'b1101, 7'b0001111, 1'b0};
        tbl[7]  = '{4'd13, 4'd7,  4'b1110, 7'b0000001, 1'b1};
        tbl[8]  = '{4'd15, 4'd0,  4'b0111, 7'b0100100, 1'b0};
        tbl[9]  = '{4'd15, 4'd0,  4'b1011, 7'b1001111, 1'b0};
        tbl[10] = '{4'd15, 4'd0,  4'b1101, 7'b0000001, 1'b0};
        tbl[11] = '{4'd15, 4'd0,  4'b1110, 7'b0000001, 1'b1};
        tbl[12] = '{4'd2,  4'd9,  4'b0111, 7'b0010010, 1'b0};
        tbl[13] = '{4'd2,  4'd9,  4'b1011, 7'b0000001, 1'b1};
        tbl[14] = '{4'd2,  4'd9,  4'b1101, 7'b0000100, 1'b0};
        tbl[15] = '{4'd2,  4'd9,  4'b1110, 7'b0000001, 1'b1};
        tbl[16] = '{4'd9,  4'd10, 4'b0111, 7'b0000100, 1'b0};
        tbl[17] = '{4'd9,  4'd10, 4'b1011, 7'b0000001, 1'b1};
        tbl[18] = '{4'd9,  4'd10, 4'b1101, 7'b0000001, 1'b0};
        tbl[19] = '{4'd9,  4'd10, 4'b1110, 7'b1001111, 1'b0};
        tbl[20] = '{4'd4,  4'd12, 4'b0111, 7'b1001100, 1'b0};
        tbl[21] = '{4'd4,  4'd12, 4'b1011, 7'b0000001, 1'b1};
        tbl[22] = '{4'd4,  4'd12, 4'b1101, 7'b0010010, 1'b0};
        tbl[23] = '{4'd4,  4'd12, 4'b1110, 7'b1001111, 1'b0};

        // Reset with nonzero inputs: shadows must still start at zero.
        rst   = 1'b1;
        en    = 1'b1;
        num_a = 4'd5;
        num_b = 4'd5;
        #22;
        chk("reset an", 32'(an), 32'(Dark4));
        chk("reset seg", 32'(seg), 32'(Dark7));
        chk("reset frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Six back-to-back frames; next frame's inputs change during slot 1.
        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 8; c++) begin
                    step();
                    if (s == 1 && c == 3 && f < 5) begin
                        num_a = tbl[(f + 1) * 4].na;
                        num_b = tbl[(f + 1) * 4].nb;
                    end
                    r = tbl[f * 4 + s];
                    if (c < 2 || (Lz && r.lz)) begin
                        exp_an  = Dark4;
                        exp_seg = Dark7;
                    end else begin
                        exp_an  = r.an;
                        exp_seg = r.seg;
                    end
                    chk($sformatf("f%0d s%0d c%0d an", f, s, c), 32'(an), 32'(exp_an));
                    chk($sformatf("f%0d s%0d c%0d seg", f, s, c), 32'(seg), 32'(exp_seg));
                    chk($sformatf("f%0d s%0d c%0d frame_done", f, s, c), 32'(frame_done),
                        32'(s == 3 && c == 7));
                    chk($sformatf("f%0d s%0d c%0d one digit", f, s, c),
                        32'($countones(~an) <= 1), 32'd1);
                end
            end
        end

        // Reset mid-slot: state slot 2, cnt 5 after 21 edges of the frame.
        for (int k = 0; k < 21; k++) step();
        chk("pre-reset an", 32'(an), 32'(4'b1101));
        chk("pre-reset seg", 32'(seg), 32'(7'b0010010));
        rst = 1'b1;
        #1;
        chk("async reset an", 32'(an), 32'(Dark4));
        chk("async reset seg", 32'(seg), 32'(Dark7));
        chk("async reset frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post-reset dark0 an", 32'(an), 32'(Dark4));
        step();
        chk("post-reset dark1 an", 32'(an), 32'(Dark4));
        step();
        chk("post-reset lit an", 32'(an), 32'(4'b0111));
        chk("post-reset lit seg", 32'(seg), 32'(7'b0000001));

        // Enable hold: advance to state slot 2, cnt 4.
        for (int k = 0; k < 17; k++) step();
        chk("pre-hold an", 32'(an), 32'(4'b1101));
        chk("pre-hold seg", 32'(seg), 32'(7'b0000001));
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("hold %0d an", k), 32'(an), 32'(Dark4));
            chk($sformatf("hold %0d seg", k), 32'(seg), 32'(Dark7));
        end
        en = 1'b1;
        // Edge 1..4: slot 2 cnt 4..7; 5,6: slot 3 dark; 7..11: slot 3 lit.
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k <= 4) begin
                exp_an  = 4'b1101;
                exp_seg = 7'b0000001;
            end else if (k <= 6 || Lz) begin
                exp_an  = Dark4;
                exp_seg = Dark7;
            end else begin
                exp_an  = 4'b1110;
                exp_seg = 7'b0000001;
            end
            chk($sformatf("resume %0d an", k), 32'(an), 32'(exp_an));
            chk($sformatf("resume %0d seg", k), 32'(seg), 32'(exp_seg));
            chk($sformatf("resume %0d frame_done", k), 32'(frame_done), 32'd0);
        end

        // en low exactly when cnt is all ones: the tick must not happen.
        en = 1'b0;
        step();
        chk("no-tick an", 32'(an), 32'(Dark4));
        chk("no-tick frame_done", 32'(frame_done), 32'd0);
        en = 1'b1;
        step();
        chk("late tick an", 32'(an), 32'(Lz ? Dark4 : 4'b1110));
        chk("late tick frame_done", 32'(frame_done), 32'd1);
        step();
        chk("after tick frame_done", 32'(frame_done), 32'd0);
        chk("after tick an", 32'(an), 32'(Dark4));
        step();
        step();
        chk("new snapshot an", 32'(an), 32'(4'b0111));
        chk("new snapshot seg", 32'(seg), 32'(7'b1001100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
